// File: rtl/wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter_if
// Description : Write-back arbiter bus bundle (ALU result, load return, issue
//               tracking, register-file write port and scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_arbiter_if;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_stall;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [31:0] pending;
    logic        WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;

    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
               iss_valid, iss_rd,
        output alu_stall, mem_ready, pending, WE3, A3, WD3
    );

    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
               iss_valid, iss_rd,
        input  alu_stall, mem_ready, pending, WE3, A3, WD3
    );
endinterface
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Register-file write-back arbiter between single-cycle ALU
//               results and a load-result FIFO, with anti-starvation and a
//               pending-load scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
    parameter int STARVE_MAX = 3,
    parameter int QDEPTH     = 2
) (
    input  wire logic   CLK,
    input  wire logic   RST,
    wb_arbiter_if.slave bus
);

    localparam int c_PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int c_CW = $clog2(QDEPTH + 1);
    localparam int c_SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [c_CW-1:0] c_QDEPTH = c_CW'(QDEPTH);
    localparam logic [c_SW-1:0] c_SMAX   = c_SW'(STARVE_MAX);
    localparam logic [c_PW-1:0] c_PLAST  = c_PW'(QDEPTH - 1);

    logic [4:0]      r_q_rd   [QDEPTH];
    logic [31:0]     r_q_data [QDEPTH];
    logic [c_PW-1:0] r_wptr;
    logic [c_PW-1:0] r_rptr;
    logic [c_CW-1:0] r_count;
    logic [c_SW-1:0] r_starve;
    logic [31:0]     r_pending;
    logic            r_we;
    logic [4:0]      r_a3;
    logic [31:0]     r_wd;

    logic            w_nonempty;
    logic            w_ready;
    logic            w_push;
    logic            w_override;
    logic            w_alu_win;
    logic            w_pop;
    logic            w_sel;
    logic [4:0]      w_head_rd;
    logic [31:0]     w_head_data;
    logic [4:0]      w_sel_rd;
    logic [31:0]     w_sel_data;
    logic [c_SW-1:0] w_starve_nxt;
    logic [31:0]     w_pending_nxt;

    // Arbitration uses only registered queue state, so a push is never popped
    // in its own cycle.
    assign w_nonempty  = (r_count != '0);
    assign w_ready     = RST && (r_count < c_QDEPTH);
    assign w_push      = bus.mem_valid && w_ready;
    assign w_override  = (r_starve == c_SMAX) && w_nonempty;
    assign w_alu_win   = !w_override && bus.alu_valid;
    assign w_pop       = w_override || (!bus.alu_valid && w_nonempty);
    assign w_sel       = w_alu_win || w_pop;
    assign w_head_rd   = r_q_rd[r_rptr];
    assign w_head_data = r_q_data[r_rptr];
    assign w_sel_rd    = w_alu_win ? bus.alu_rd   : w_head_rd;
    assign w_sel_data  = w_alu_win ? bus.alu_data : w_head_data;

    always_comb begin
        w_starve_nxt = '0;
        if (w_alu_win && w_nonempty) begin
            w_starve_nxt = (r_starve == c_SMAX) ? r_starve : r_starve + 1'b1;
        end
    end

    // Clear first so a same-cycle issue to the same register wins.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_pop && (w_head_rd != 5'd0)) begin
            w_pending_nxt[w_head_rd] = 1'b0;
        end
        if (bus.iss_valid && (bus.iss_rd != 5'd0)) begin
            w_pending_nxt[bus.iss_rd] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_q_rd[r_wptr]   <= bus.mem_rd;
            r_q_data[r_wptr] <= bus.mem_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_starve  <= '0;
            r_pending <= '0;
            r_we      <= 1'b0;
            r_a3      <= '0;
            r_wd      <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == c_PLAST) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == c_PLAST) ? '0 : r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            r_starve  <= w_starve_nxt;
            r_pending <= w_pending_nxt;
            r_we      <= w_sel && (w_sel_rd != 5'd0);
            if (w_sel) begin
                r_a3 <= w_sel_rd;
                r_wd <= w_sel_data;
            end
        end
    end

    assign bus.mem_ready = w_ready;
    assign bus.alu_stall = RST && w_override && bus.alu_valid;
    assign bus.pending   = r_pending;
    assign bus.WE3       = r_we;
    assign bus.A3        = r_a3;
    assign bus.WD3       = r_wd;

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 3, meaning the number of consecutive cycles the ALU may win while the load queue is nonempty.
REQ-002 SHALL have parameter QDEPTH, default 2, meaning the number of load-result queue entries.
REQ-003 SHALL have port CLK  input  1  clock, with all state updated on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port alu_valid  input  1  single-cycle ALU result present this cycle.
REQ-006 SHALL have port alu_rd  input  5  ALU destination register.
REQ-007 SHALL have port alu_data  input  32  ALU result.
REQ-008 SHALL have port alu_stall  output  1  ALU result not taken this cycle; the issuer holds it.
REQ-009 SHALL have port mem_valid  input  1  load result offered.
REQ-010 SHALL have port mem_ready  output  1  load result accepted when high together with mem_valid.
REQ-011 SHALL have port mem_rd  input  5  load destination register.
REQ-012 SHALL have port mem_data  input  32  load data.
REQ-013 SHALL have port iss_valid  input  1  load issued; marks its destination as pending.
REQ-014 SHALL have port iss_rd  input  5  destination register of the issued load.
REQ-015 SHALL have port pending  output  32  scoreboard, one bit per register; bit 0 is always 0.
REQ-016 SHALL have port WE3  output  1  register-file write enable, registered.
REQ-017 SHALL have port A3  output  5  register-file write address, registered.
REQ-018 SHALL have port WD3  output  32  register-file write data, registered.

Function
REQ-019 SHALL store accepted load results in a FIFO of QDEPTH entries, preserving arrival order.
REQ-020 SHALL drive mem_ready = RST && (count < QDEPTH), based on the registered count; a full queue refuses a push even in a cycle with a pop.
REQ-021 SHALL select the write source each cycle by priority: starvation override, then ALU, then queue head.
REQ-022 SHALL apply starvation override when starve_cnt == STARVE_MAX and the queue is nonempty: pop the head, assert alu_stall = alu_valid, and discard the ALU input for this cycle.
REQ-023 SHALL otherwise, when alu_valid = 1, take the ALU result, hold alu_stall = 0 and leave the queue unchanged.
REQ-024 SHALL otherwise pop the queue head when the queue is nonempty.
REQ-025 SHALL increment starve_cnt when the ALU wins while the queue is nonempty, and clear it on any pop or when the queue is empty; starve_cnt saturates at STARVE_MAX.
REQ-026 SHALL, one cycle after selection, present the selected result as WE3 = 1 with A3 = rd and WD3 = data; with no selection, WE3 = 0 and A3/WD3 hold their values.
REQ-027 SHALL force WE3 = 0 for rd = 0, while still popping the entry and still counting it as a write for arbitration.
REQ-028 SHALL accept a push into an empty queue in the same cycle and make it eligible for pop the following cycle; there is no bypass.
REQ-029 SHALL set pending[iss_rd] on iss_valid when iss_rd != 0.
REQ-030 SHALL clear pending[rd] in the cycle a queue entry with that rd is popped.
REQ-031 SHALL let set win over clear when both hit the same rd in one cycle.
REQ-032 SHALL leave pending unchanged on ALU writes.
REQ-033 SHALL produce pending directly from the scoreboard register, with no combinational path from inputs.
REQ-034 SHALL keep count in the range 0..QDEPTH and the pointers wrapping modulo QDEPTH; simultaneous push and pop leaves count unchanged.

Reset
REQ-035 SHALL, on a rising CLK edge with RST = 0, clear the queue (count = 0, pointers = 0), starve_cnt, pending, WE3, A3 and WD3.
REQ-036 SHALL hold mem_ready = 0 while RST = 0.
REQ-037 SHALL hold alu_stall = 0 while RST = 0.
REQ-038 SHALL discard any entry in flight or queued at reset, including one accepted in the reset cycle.
REQ-039 SHALL, on the first cycle after RST returns to 1, drive mem_ready = 1 and WE3 = 0.

Verification
REQ-040 SHALL cover: ALU only, alu_valid = 1, rd = 5, data = 0x1234 -> next cycle WE3 = 1, A3 = 5, WD3 = 0x1234; pending = 0.
REQ-041 SHALL cover: iss rd = 7, then a load rd = 7, data = 0xDEAD accepted with no ALU traffic -> pending[7] = 1 until the pop cycle; WE3 with A3 = 7 one cycle after the pop.
REQ-042 SHALL cover: two loads queued while alu_valid is held high -> mem_ready = 0 when count = 2; ALU wins 3 cycles, then alu_stall = 1 in cycle 4 and the load head is written; starve_cnt clears.
REQ-043 SHALL cover: load with rd = 0 -> pop occurs, WE3 stays 0, count decrements.
REQ-044 SHALL cover: iss_valid rd = 9 in the same cycle as the pop of an older rd = 9 -> pending[9] remains 1.
REQ-045 SHALL cover: RST = 0 asserted with count = 2 and pending = 0x0000_0880 -> next cycle count = 0, pending = 0, WE3 = 0, mem_ready = 0 during reset and 1 after.
